fpnew_divsqrt_req_fifo: RTL and testbench

//   Request buffer directly upstream of the multi-cycle DIV/SQRT unit. Accepts

---
 rtl/fpnew_divsqrt_req_fifo.sv | 140 ++++++++++++++
 tb/tb_fpnew_divsqrt_req_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_req_fifo.sv
// In-order request buffer in front of the iterative DIV/SQRT unit.
// Circular storage with a registered occupancy count, a synchronous flush, and no fall-through.
module fpnew_divsqrt_req_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_WIDTH = 8,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*WIDTH-1:0]     operands_i,
  input  logic [2:0]             rnd_mode_i,
  input  logic [3:0]             op_i,
  input  logic [2:0]             dst_fmt_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   flush_i,
  output logic [2*WIDTH-1:0]     operands_o,
  output logic [2:0]             rnd_mode_o,
  output logic [3:0]             op_o,
  output logic [2:0]             dst_fmt_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CNT_WIDTH-1:0]   usage_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  typedef struct packed {
    logic [2*WIDTH-1:0]   operands;
    logic [2:0]           rnd_mode;
    logic [3:0]           op;
    logic [2:0]           dst_fmt;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t                 mem [DEPTH];
  entry_t                 wr_entry;
  entry_t                 head;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr_next;
  logic [PTR_WIDTH-1:0]   wr_ptr_next;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_WIDTH'(1);
    end
  endfunction

  // Both handshake flags depend only on the registered count, so neither side sees the other combinationally.
  assign in_ready_o  = (count != CNT_WIDTH'(DEPTH));
  assign out_valid_o = (count != CNT_WIDTH'(0));
  assign usage_o     = count;
  assign busy_o      = out_valid_o;
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_entry.operands = operands_i;
    wr_entry.rnd_mode = rnd_mode_i;
    wr_entry.op       = op_i;
    wr_entry.dst_fmt  = dst_fmt_i;
    wr_entry.tag      = tag_i;
  end

  // Next pointer and occupancy values; flush returns everything to the origin.
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr);
      end else begin
        wr_ptr_next = wr_ptr;
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr);
      end else begin
        rd_ptr_next = rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_next = count + CNT_WIDTH'(1);
        2'b01:   count_next = count - CNT_WIDTH'(1);
        default: count_next = count;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // Storage is deliberately unreset; validity comes from the count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Head data is gated to zero whenever nothing valid is stored.
  always_comb begin
    head = '0;
    if (out_valid_o) begin
      head = mem[rd_ptr];
    end else begin
      head = '0;
    end
  end

  assign operands_o = head.operands;
  assign rnd_mode_o = head.rnd_mode;
  assign op_o       = head.op;
  assign dst_fmt_o  = head.dst_fmt;
  assign tag_o      = head.tag;

endmodule

// File: tb/tb_fpnew_divsqrt_req_fifo.sv
// Directed self-checking bench for fpnew_divsqrt_req_fifo (default parameters, DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fpnew_divsqrt_req_fifo;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAG_WIDTH = 8;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic [2*WIDTH-1:0]   operands_i;
  logic [2:0]           rnd_mode_i;
  logic [3:0]           op_i;
  logic [2:0]           dst_fmt_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [2*WIDTH-1:0]   operands_o;
  logic [2:0]           rnd_mode_o;
  logic [3:0]           op_o;
  logic [2:0]           dst_fmt_o;
  logic [TAG_WIDTH-1:0] tag_o;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] usage;
  logic                 busy;

  int checks;
  int errors;

  localparam logic [2*WIDTH-1:0] DIV_OPS = {64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};

  fpnew_divsqrt_req_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .operands_i(operands_i), .rnd_mode_i(rnd_mode_i), .op_i(op_i),
    .dst_fmt_i(dst_fmt_i), .tag_i(tag_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .operands_o(operands_o), .rnd_mode_o(rnd_mode_o), .op_o(op_o),
    .dst_fmt_o(dst_fmt_o), .tag_o(tag_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .usage_o(usage), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic r);
    in_valid  = v;
    tag_i     = t;
    out_ready = r;
    operands_i = {56'h0, t, 56'h0, t};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    rnd_mode_i = 3'd0;
    op_i = 4'd4;
    dst_fmt_i = 3'd0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_ready", 128'(in_ready), 128'd1);
    check("rst_usage", 128'(usage), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ops", operands_o, 128'd0);
    rst = 1'b0;

    // order: three pushes with the consumer stalled, then drain
    @(negedge clk); drive(1'b1, 8'h11, 1'b0);
    @(negedge clk); check("first_latency", 128'(out_valid), 128'd1);
    check("first_tag", 128'(tag_o), 128'h11);
    drive(1'b1, 8'h22, 1'b0);
    @(negedge clk); drive(1'b1, 8'h33, 1'b0);
    @(negedge clk); drive(1'b0, 8'h00, 1'b1);
    check("ord_u3", 128'(usage), 128'd3);
    check("ord_t11", 128'(tag_o), 128'h11);
    check("ord_busy", 128'(busy), 128'd1);
    @(negedge clk);
    check("ord_u2", 128'(usage), 128'd2);
    check("ord_t22", 128'(tag_o), 128'h22);
    @(negedge clk);
    check("ord_u1", 128'(usage), 128'd1);
    check("ord_t33", 128'(tag_o), 128'h33);
    check("ord_ops33", operands_o, {56'h0, 8'h33, 56'h0, 8'h33});
    @(negedge clk);
    check("ord_u0", 128'(usage), 128'd0);
    check("ord_empty", 128'(out_valid), 128'd0);
    check("ord_tag0", 128'(tag_o), 128'd0);
    drive(1'b0, 8'h00, 1'b0);

    // full: four pushes, then pop with push held
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 8'hA0 + 8'(i), 1'b0);
    end
    @(negedge clk);
    check("full_ready", 128'(in_ready), 128'd0);
    check("full_usage", 128'(usage), 128'd4);
    drive(1'b1, 8'hA4, 1'b1);
    @(negedge clk);
    check("full_nopush_u", 128'(usage), 128'd3);
    check("full_rise", 128'(in_ready), 128'd1);
    check("full_head", 128'(tag_o), 128'hA1);
    drive(1'b1, 8'hA4, 1'b0);
    @(negedge clk);
    check("full_5th_u", 128'(usage), 128'd4);
    check("full_5th_rdy", 128'(in_ready), 128'd0);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 1; i < 5; i++) begin
      check("full_drain", 128'(tag_o), 128'(8'hA0 + 8'(i)));
      @(negedge clk);
    end
    check("full_drained", 128'(usage), 128'd0);
    drive(1'b0, 8'h00, 1'b0);

    // concurrent push/pop at count 2 across pointer wrap
    @(negedge clk); drive(1'b1, 8'hB0, 1'b0);
    @(negedge clk); drive(1'b1, 8'hB1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("conc_usage", 128'(usage), 128'd2);
      check("conc_tag", 128'(tag_o), 128'(8'hB0 + 8'(i)));
      drive(1'b1, 8'hB2 + 8'(i), 1'b1);
    end
    @(negedge clk);
    check("conc_end_u", 128'(usage), 128'd2);
    check("conc_end_t", 128'(tag_o), 128'hBA);
    drive(1'b1, 8'hC0, 1'b0);

    // flush overrides simultaneous push and pop
    @(negedge clk);
    check("fl_pre_u", 128'(usage), 128'd3);
    flush = 1'b1;
    drive(1'b1, 8'hC1, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("fl_usage", 128'(usage), 128'd0);
    check("fl_valid", 128'(out_valid), 128'd0);
    check("fl_ready", 128'(in_ready), 128'd1);
    check("fl_tag", 128'(tag_o), 128'd0);
    @(negedge clk);
    check("fl_noadd", 128'(usage), 128'd0);

    // stall: DIV head held for five cycles, illegal op behind it
    operands_i = DIV_OPS; op_i = 4'd4; rnd_mode_i = 3'd1; dst_fmt_i = 3'd0;
    tag_i = 8'hE0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    operands_i = 128'h0; op_i = 4'hF; rnd_mode_i = 3'd4; dst_fmt_i = 3'd3; tag_i = 8'hE1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_ops", operands_o, DIV_OPS);
      check("stall_op", 128'(op_o), 128'd4);
      check("stall_tag", 128'(tag_o), 128'hE0);
      @(negedge clk);
    end
    check("stall_rnd", 128'(rnd_mode_o), 128'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_pop_tag", 128'(tag_o), 128'hE1);
    check("illegal_op", 128'(op_o), 128'hF);
    check("illegal_fmt", 128'(dst_fmt_o), 128'd3);
    check("illegal_rnd", 128'(rnd_mode_o), 128'd4);
    check("stall_u1", 128'(usage), 128'd1);

    // async reset with three entries stored
    op_i = 4'd5; rnd_mode_i = 3'd0; dst_fmt_i = 3'd0;
    drive(1'b1, 8'hF0, 1'b0);
    @(negedge clk); drive(1'b1, 8'hF1, 1'b0);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0);
    check("mid_u3", 128'(usage), 128'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_usage", 128'(usage), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    check("mid_rst_tag", 128'(tag_o), 128'd0);
    check("mid_rst_ops", operands_o, 128'd0);
    check("mid_rst_op", 128'(op_o), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_u", 128'(usage), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
